// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the VGA colour-depth reducer: MODE
//               encodings, the 4x4 Bayer matrix and the threshold helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'd0,
        MODE_SPATIAL  = 2'd1,
        MODE_TEMPORAL = 2'd2,
        MODE_ROUND    = 2'd3
    } mode_e;

    // Row-major 4x4 ordered-dither matrix; entry index is {y[1:0], x[1:0]}.
    localparam logic [0:15][3:0] BAYER = {
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Scale the 0..15 Bayer entry down to the 0..2^d-1 range of the dropped bits.
    function automatic logic [3:0] bayer_threshold(input logic [3:0] idx, input int unsigned d);
        return BAYER[idx] >> (4 - d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_dither_chan.sv
`default_nettype none
// ============================================================================
// Module      : vga_dither_chan
// Description : Combinational per-channel reduction (truncate, ordered dither
//               or round-to-nearest) with saturation and blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_dither_chan import vga_pkg::*; #(
    parameter int IN_BITS  = 3,
    parameter int OUT_BITS = 2
) (
    input  logic [IN_BITS-1:0]  i_pix,
    input  logic [3:0]          i_thresh,
    input  mode_e               i_mode,
    input  logic                i_blank,
    output logic [OUT_BITS-1:0] o_pix
);

    localparam int D  = IN_BITS - OUT_BITS;
    // One extra bit so the biased sum never wraps.
    localparam int SW = IN_BITS + 1;

    logic [SW-1:0] w_add;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_res;
    logic          w_sat;

    // Bias, shift away the dropped bits and clamp to the output range.
    always_comb begin
        w_add = '0;
        unique case (i_mode)
            MODE_SPATIAL, MODE_TEMPORAL: w_add = SW'(i_thresh);
            MODE_ROUND:                  w_add = SW'(1 << (D - 1));
            default:                     w_add = '0;
        endcase
        w_sum = {1'b0, i_pix} + w_add;
        w_res = w_sum >> D;
        // Any bit at or above OUT_BITS means the result overflowed the DAC range.
        w_sat = |w_res[SW-1:OUT_BITS];
        if (i_blank) begin
            o_pix = '0;
        end else if (w_sat) begin
            o_pix = '1;
        end else begin
            o_pix = w_res[OUT_BITS-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_dither_reducer.sv
`default_nettype none
// ============================================================================
// Module      : vga_dither_reducer
// Description : Two-stage colour-depth reducer for the VGA DAC with 4x4
//               ordered dither (optionally frame-rotated) and aligned syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_dither_reducer import vga_pkg::*; #(
    parameter int IN_BITS         = 3,
    parameter int OUT_BITS        = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                CLKVGA,
    input  logic                nRST,
    input  logic                iHS,
    input  logic                iVS,
    input  logic [IN_BITS-1:0]  iRED,
    input  logic [IN_BITS-1:0]  iGREEN,
    input  logic [IN_BITS-1:0]  iBLUE,
    input  logic [1:0]          MODE,
    output logic                HS,
    output logic                VS,
    output logic [OUT_BITS-1:0] RED,
    output logic [OUT_BITS-1:0] GREEN,
    output logic [OUT_BITS-1:0] BLUE,
    output logic [1:0]          FRAME
);

    localparam int   D           = IN_BITS - OUT_BITS;
    localparam logic C_SYNC_IDLE = SYNC_ACTIVE_LOW;

    generate
        if (IN_BITS < 2 || IN_BITS > 8 || OUT_BITS < 1 || D < 1 || D > 4) begin : g_bad_params
            $error("vga_dither_reducer: need 2<=IN_BITS<=8 and 1<=IN_BITS-OUT_BITS<=4");
        end
    endgenerate

    logic        w_hs_act, w_vs_act, w_hs_edge, w_vs_edge;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [1:0]  x_q, x_d, y_q, y_d, frame_q, frame_d;
    mode_e       w_mode;
    logic [1:0]  w_ix, w_iy;

    logic [2:0][IN_BITS-1:0]  s1_pix_q, s1_pix_d;
    mode_e                    s1_mode_q, s1_mode_d;
    logic [3:0]               s1_thresh_q, s1_thresh_d;
    logic                     s1_blank_q, s1_blank_d;
    logic                     s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;

    logic [2:0][OUT_BITS-1:0] w_chan_pix;
    logic [2:0][OUT_BITS-1:0] pix_q, pix_d;
    logic                     hs_q, hs_d, vs_q, vs_d;

    // Sync edge detection and the x/y/frame position counters.
    always_comb begin
        w_hs_act  = (iHS != C_SYNC_IDLE);
        w_vs_act  = (iVS != C_SYNC_IDLE);
        w_hs_edge = w_hs_act & ~hs_prev_q;
        w_vs_edge = w_vs_act & ~vs_prev_q;
        hs_prev_d = w_hs_act;
        vs_prev_d = w_vs_act;

        x_d = x_q;
        if (w_hs_edge) begin
            x_d = 2'd0;
        end else if (!w_hs_act) begin
            x_d = x_q + 2'd1;
        end

        // A VS edge outranks a coincident HS edge so the new frame starts at row 0.
        y_d = y_q;
        if (w_vs_edge) begin
            y_d = 2'd0;
        end else if (w_hs_edge) begin
            y_d = y_q + 2'd1;
        end

        frame_d = w_vs_edge ? frame_q + 2'd1 : frame_q;
    end

    // Threshold lookup and stage-1/stage-2 next values.
    always_comb begin
        w_mode = mode_e'(MODE);
        w_ix   = x_q;
        w_iy   = y_q;
        if (w_mode == MODE_TEMPORAL) begin
            w_ix = x_q + {1'b0, frame_q[0]};
            w_iy = y_q + {1'b0, frame_q[1]};
        end

        s1_pix_d    = {iBLUE, iGREEN, iRED};
        s1_mode_d   = w_mode;
        s1_thresh_d = bayer_threshold({w_iy, w_ix}, D);
        s1_blank_d  = w_hs_act | w_vs_act;
        s1_hs_d     = iHS;
        s1_vs_d     = iVS;

        pix_d = w_chan_pix;
        hs_d  = s1_hs_q;
        vs_d  = s1_vs_q;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            vga_dither_chan #(
                .IN_BITS  (IN_BITS),
                .OUT_BITS (OUT_BITS)
            ) u_chan (
                .i_pix    (s1_pix_q[gi]),
                .i_thresh (s1_thresh_q),
                .i_mode   (s1_mode_q),
                .i_blank  (s1_blank_q),
                .o_pix    (w_chan_pix[gi])
            );
        end
    endgenerate

    // State and pipeline registers; syncs reset to their inactive level.
    always_ff @(posedge CLKVGA or negedge nRST) begin
        if (!nRST) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            x_q         <= 2'd0;
            y_q         <= 2'd0;
            frame_q     <= 2'd0;
            s1_pix_q    <= '0;
            s1_mode_q   <= MODE_TRUNC;
            s1_thresh_q <= 4'd0;
            s1_blank_q  <= 1'b0;
            s1_hs_q     <= C_SYNC_IDLE;
            s1_vs_q     <= C_SYNC_IDLE;
            pix_q       <= '0;
            hs_q        <= C_SYNC_IDLE;
            vs_q        <= C_SYNC_IDLE;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_q     <= frame_d;
            s1_pix_q    <= s1_pix_d;
            s1_mode_q   <= s1_mode_d;
            s1_thresh_q <= s1_thresh_d;
            s1_blank_q  <= s1_blank_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            pix_q       <= pix_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign HS    = hs_q;
    assign VS    = vs_q;
    assign RED   = pix_q[0];
    assign GREEN = pix_q[1];
    assign BLUE  = pix_q[2];
    assign FRAME = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_dither_reducer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_dither_reducer
// Description : Self-checking bench for vga_dither_reducer (3->2 and 6->2
//               builds) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_dither_reducer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ihs   = 1'b1;
    logic       ivs   = 1'b1;
    logic [2:0] ir = '0, ig = '0, ib = '0;
    logic [5:0] iw = '0;
    logic [1:0] imode = '0;
    logic       hs, vs, hs6, vs6;
    logic [1:0] r, g, b, fr, r6, g6, b6, fr6;

    always #5 clk = ~clk;

    vga_dither_reducer #(.IN_BITS(3), .OUT_BITS(2), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .CLKVGA(clk), .nRST(rst_n), .iHS(ihs), .iVS(ivs),
        .iRED(ir), .iGREEN(ig), .iBLUE(ib), .MODE(imode),
        .HS(hs), .VS(vs), .RED(r), .GREEN(g), .BLUE(b), .FRAME(fr)
    );

    vga_dither_reducer #(.IN_BITS(6), .OUT_BITS(2), .SYNC_ACTIVE_LOW(1'b1)) dut6 (
        .CLKVGA(clk), .nRST(rst_n), .iHS(ihs), .iVS(ivs),
        .iRED(iw), .iGREEN(iw), .iBLUE(iw), .MODE(imode),
        .HS(hs6), .VS(vs6), .RED(r6), .GREEN(g6), .BLUE(b6), .FRAME(fr6)
    );

    typedef struct packed {
        logic       hs, vs, h6, v6;
        logic [1:0] r, g, b, w, wg, wb;
    } px_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   bayer[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int   m_x, m_y, m_f;
    bit   m_hp, m_vp;
    px_t  pend;

    // Expected reduced value for one pixel at the model's current position.
    function automatic int ref_px(int v, int md, int inb, int outb, bit blank);
        int d, mx, xi, yi, t, q;
        d  = inb - outb;
        mx = (1 << outb) - 1;
        if (blank) return 0;
        case (md)
            0: return v / (1 << d);
            1, 2: begin
                xi = (md == 2) ? (m_x + m_f % 2) % 4 : m_x;
                yi = (md == 2) ? (m_y + m_f / 2) % 4 : m_y;
                t  = bayer[yi * 4 + xi] / (1 << (4 - d));
                q  = (v + t) / (1 << d);
                return (q > mx) ? mx : q;
            end
            default: begin
                q = (v + (1 << (d - 1))) / (1 << d);
                return (q > mx) ? mx : q;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_f = 0; m_hp = 1'b0; m_vp = 1'b0;
        pend = '0;
        pend.hs = 1'b1; pend.vs = 1'b1; pend.h6 = 1'b1; pend.v6 = 1'b1;
    endtask

    // Drive one pixel (entered and left at a falling edge); returns what the DUT
    // shows after the rising edge and what the model says should be there.
    task automatic step(input bit hact, input bit vact, input int rv, input int gv, input int bv,
                        input int wv, input int md, output px_t obs, output px_t exp,
                        output int f_obs, output int f6_obs, output int f_exp);
        px_t cur;
        bit  blank, he, ve;
        ihs = ~hact; ivs = ~vact;
        ir = 3'(rv); ig = 3'(gv); ib = 3'(bv); iw = 6'(wv); imode = 2'(md);
        blank  = hact | vact;
        cur.hs = ~hact; cur.vs = ~vact; cur.h6 = ~hact; cur.v6 = ~vact;
        cur.r  = 2'(ref_px(rv, md, 3, 2, blank));
        cur.g  = 2'(ref_px(gv, md, 3, 2, blank));
        cur.b  = 2'(ref_px(bv, md, 3, 2, blank));
        cur.w  = 2'(ref_px(wv, md, 6, 2, blank));
        cur.wg = cur.w; cur.wb = cur.w;
        @(posedge clk);
        he = hact && !m_hp;
        ve = vact && !m_vp;
        if (he) m_x = 0; else if (!hact) m_x = (m_x + 1) % 4;
        if (ve) m_y = 0; else if (he) m_y = (m_y + 1) % 4;
        if (ve) m_f = (m_f + 1) % 4;
        m_hp = hact; m_vp = vact;
        #1;
        obs.hs = hs; obs.vs = vs; obs.h6 = hs6; obs.v6 = vs6;
        obs.r = r; obs.g = g; obs.b = b; obs.w = r6; obs.wg = g6; obs.wb = b6;
        exp  = pend;
        pend = cur;
        f_obs = int'(fr); f6_obs = int'(fr6); f_exp = m_f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ihs = 1'($urandom); ivs = 1'($urandom); imode = 2'($urandom);
            ir = 3'($urandom); ig = 3'($urandom); ib = 3'($urandom); iw = 6'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({hs, vs, hs6, vs6, r, g, b, fr, r6, g6, b6, fr6} !== 20'hF0000) begin
                n_err++;
                $display("FAIL reset%0d: got %b want %b", i,
                         {hs, vs, hs6, vs6, r, g, b, fr, r6, g6, b6, fr6}, 20'hF0000);
            end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_truncate();
        int  vin[6]  = '{3, 7, 4, 5, 2, 6};
        bit  hin[6]  = '{0, 0, 0, 1, 0, 0};
        bit  vvin[6] = '{0, 0, 0, 0, 1, 0};
        int  lit[3]  = '{1, 3, 2};
        int  got[7];
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) step(hin[i], vvin[i], vin[i], $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 63), 0, o, e, fo, f6o, fe);
            else step(0, 0, 0, 0, 0, 0, 0, o, e, fo, f6o, fe);
            got[i] = int'(o.r);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL trunc step%0d: got %h want %h", i, o, e); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i + 1] !== lit[i]) begin
                n_err++; $display("FAIL trunc lit%0d: got %0d want %0d", i, got[i + 1], lit[i]);
            end
        end
    endtask

    task automatic test_spatial();
        int  got[14];
        int  lit0[4] = '{1, 2, 1, 2};
        int  lit1[4] = '{2, 1, 2, 1};
        int  vin;
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            vin = (i >= 9) ? 7 : 3;
            if (i < 13) step(i == 4, 0, vin, $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 63), 1, o, e, fo, f6o, fe);
            else step(0, 0, 0, 0, 0, 0, 1, o, e, fo, f6o, fe);
            got[i] = int'(o.r);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL spatial step%0d: got %h want %h", i, o, e); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i + 1] !== lit0[i] || got[i + 6] !== lit1[i] || got[i + 10] !== 3) begin
                n_err++;
                $display("FAIL spatial x%0d: got y0=%0d y1=%0d sat=%0d want %0d %0d 3",
                         i, got[i + 1], got[i + 6], got[i + 10], lit0[i], lit1[i]);
            end
        end
    endtask

    // Coincident HS+VS pulses between pixels return to (0,0) and bump the frame.
    task automatic test_temporal();
        int  pat[4] = '{1, 2, 2, 1};
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            step(0, 0, 3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63), 2,
                 o, e, fo, f6o, fe);
            n_cmp++;
            if (o !== e || fo !== f || f6o !== fe) begin
                n_err++; $display("FAIL temporal px f%0d: got %h frame %0d want %h frame %0d", f, o, fo, e, f);
            end
            step(1, 1, 0, 0, 0, 0, 2, o, e, fo, f6o, fe);
            n_cmp++;
            if (o !== e || int'(o.r) !== pat[f] || fo !== (f + 1) % 4 || f6o !== fe) begin
                n_err++;
                $display("FAIL temporal out f%0d: got %h r=%0d frame %0d want %h r=%0d frame %0d",
                         f, o, o.r, fo, e, pat[f], (f + 1) % 4);
            end
        end
    endtask

    task automatic test_round();
        int  vin[5] = '{0, 1, 3, 6, 5};
        int  lit[5] = '{0, 1, 2, 3, 0};
        px_t o, e;
        int  fo, f6o, fe;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(i == 4, 0, vin[i], $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 63), 3, o, e, fo, f6o, fe);
            else step(0, 0, 0, 0, 0, 0, 3, o, e, fo, f6o, fe);
            n_cmp++;
            if (o !== e || (i > 0 && int'(o.r) !== lit[i - 1])) begin
                n_err++;
                $display("FAIL round step%0d: got %h want %h (r=%0d)", i, o, e, (i > 0) ? lit[i - 1] : 0);
            end
        end
    endtask

    task automatic test_wide();
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        step(0, 0, 1, 2, 3, $urandom_range(0, 63), 1, o, e, fo, f6o, fe);
        step(0, 0, 1, 2, 3, 10, 1, o, e, fo, f6o, fe);
        step(0, 0, 0, 0, 0, 0, 1, o, e, fo, f6o, fe);
        n_cmp++;
        if (o !== e || o.w !== 2'd1) begin
            n_err++; $display("FAIL wide x1: got %h (w=%0d) want %h (w=1)", o, o.w, e);
        end
    endtask

    task automatic test_random();
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 6) == 0, ($urandom % 40) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 3), o, e, fo, f6o, fe);
            n_cmp++;
            if (o !== e || fo !== fe || f6o !== fe) begin
                n_err++; $display("FAIL random step%0d: got %h frame %0d want %h frame %0d", i, o, fo, e, fe);
            end
        end
    endtask

    task automatic test_reset_midline();
        int  lit[4] = '{1, 2, 1, 2};
        px_t o, e;
        int  fo, f6o, fe;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, o, e, fo, f6o, fe);
        step(1, 1, 0, 0, 0, 0, 0, o, e, fo, f6o, fe);
        for (int i = 0; i < 6; i++) step(0, 0, 7, 7, 7, 63, 0, o, e, fo, f6o, fe);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hs, vs, hs6, vs6, r, g, b, fr, r6, g6, b6, fr6} !== 20'hF0000) begin
            n_err++;
            $display("FAIL midline reset: got %b want %b", {hs, vs, hs6, vs6, r, g, b, fr, r6, g6, b6, fr6}, 20'hF0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 3, 3, 3, 0, 1, o, e, fo, f6o, fe);
            n_cmp++;
            if (o !== e || (i > 0 && int'(o.r) !== lit[i - 1])) begin
                n_err++; $display("FAIL restart step%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_truncate();
        test_spatial();
        test_temporal();
        test_round();
        test_wide();
        test_random();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
